// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I core.
// Stage strobes, write gating, memory-ready timeout and retire counter.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I_MEM_RDY,
  input  logic             D_MEM_RDY,
  input  logic             sigOP,
  input  logic             sigOpIMM,
  input  logic             sigJAL,
  input  logic             sigJALR,
  input  logic             sigBRANCH,
  input  logic             sigLOAD,
  input  logic             sigSTORE,
  input  logic             sigLUI,
  input  logic             sigAUIPC,
  input  logic             HALT_REQ,
  output logic             isIF,
  output logic             isID,
  output logic             isEX,
  output logic             isMEM,
  output logic             isWB,
  output logic             I_MEM_REQ,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic             D_MEM_REQ,
  output logic             D_MEM_WE,
  output logic             RF_WE_EN,
  output logic             ILLEGAL,
  output logic             HALTED,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] NUM_INST
);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_JAL, C_JALR, C_BRANCH, C_LOAD,
    C_STORE, C_OP, C_OPIMM, C_LUI, C_AUIPC
  } cls_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state;
  state_t           state_n;
  cls_t             cls_q;
  cls_t             id_cls;
  logic [7:0]       tcnt;
  logic             halted_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] num_q;
  logic             run;
  logic             wait_st;
  logic             rdy;
  logic             timeout;

  always_comb begin
    id_cls = C_NONE;
    priority case (1'b1)
      sigJAL:    id_cls = C_JAL;
      sigJALR:   id_cls = C_JALR;
      sigBRANCH: id_cls = C_BRANCH;
      sigLOAD:   id_cls = C_LOAD;
      sigSTORE:  id_cls = C_STORE;
      sigOP:     id_cls = C_OP;
      sigOpIMM:  id_cls = C_OPIMM;
      sigLUI:    id_cls = C_LUI;
      sigAUIPC:  id_cls = C_AUIPC;
      default:   id_cls = C_NONE;
    endcase
  end

  assign rdy     = (state == S_IF) ? I_MEM_RDY : D_MEM_RDY;
  assign wait_st = (state == S_IF) || (state == S_MEM);
  // a ready in the last allowed cycle still completes the access
  assign timeout = wait_st && !rdy && (tcnt == TO_LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IF: begin
        if (I_MEM_RDY)    state_n = S_ID;
        else if (timeout) state_n = S_HALT;
      end
      S_ID: begin
        if (HALT_REQ)              state_n = S_HALT;
        else if (id_cls == C_NONE) state_n = S_IF;
        else                       state_n = S_EX;
      end
      S_EX: begin
        if (cls_q == C_BRANCH)     state_n = S_IF;
        else if (cls_q == C_LOAD ||
                 cls_q == C_STORE) state_n = S_MEM;
        else                       state_n = S_WB;
      end
      S_MEM: begin
        if (D_MEM_RDY)
          state_n = (cls_q == C_STORE) ? S_IF : S_WB;
        else if (timeout)
          state_n = S_HALT;
      end
      S_WB:    state_n = S_IF;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IF;
    endcase
  end

  assign run       = !RST;
  assign isIF      = run && (state == S_IF);
  assign isID      = run && (state == S_ID);
  assign isEX      = run && (state == S_EX);
  assign isMEM     = run && (state == S_MEM);
  assign isWB      = run && (state == S_WB);
  assign I_MEM_REQ = isIF;
  assign IR_WE     = isIF && I_MEM_RDY;
  assign D_MEM_REQ = isMEM;
  assign D_MEM_WE  = isMEM && (cls_q == C_STORE);
  assign RF_WE_EN  = isWB;
  assign ILLEGAL   = isID && !HALT_REQ &&
                     (id_cls == C_NONE);
  assign PC_WE     = ILLEGAL
                   | (isEX && cls_q == C_BRANCH)
                   | (D_MEM_WE && D_MEM_RDY)
                   | isWB;
  assign HALTED    = halted_q;
  assign MEM_ERR   = mem_err_q;
  assign NUM_INST  = num_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IF;
      cls_q     <= C_NONE;
      tcnt      <= '0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
      num_q     <= '0;
    end else begin
      state <= state_n;
      if (state == S_ID) cls_q <= id_cls;
      if (state_n != state) tcnt <= '0;
      else if (wait_st)     tcnt <= tcnt + 8'd1;
      if (PC_WE)            num_q <= num_q + 1'b1;
      if (timeout)          mem_err_q <= 1'b1;
      if (state_n == S_HALT) halted_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Trace-model bench for multicycle_ctrl: each instruction is expanded
// into its expected per-cycle outputs from latency/handshake rules.
module tb_multicycle_ctrl;

  localparam int MT = 16;

  localparam logic [11:0] B_IF   = 12'h800;
  localparam logic [11:0] B_ID   = 12'h400;
  localparam logic [11:0] B_EX   = 12'h200;
  localparam logic [11:0] B_MEM  = 12'h100;
  localparam logic [11:0] B_WB   = 12'h080;
  localparam logic [11:0] B_IREQ = 12'h040;
  localparam logic [11:0] B_IRWE = 12'h020;
  localparam logic [11:0] B_PC   = 12'h010;
  localparam logic [11:0] B_DREQ = 12'h008;
  localparam logic [11:0] B_DWE  = 12'h004;
  localparam logic [11:0] B_RF   = 12'h002;
  localparam logic [11:0] B_ILL  = 12'h001;

  // flag bit index = priority rank
  localparam logic [8:0] F_JAL    = 9'h001;
  localparam logic [8:0] F_BRANCH = 9'h004;
  localparam logic [8:0] F_LOAD   = 9'h008;
  localparam logic [8:0] F_STORE  = 9'h010;
  localparam logic [8:0] F_OPIMM  = 9'h040;

  typedef struct packed {
    logic       rst;
    logic       irdy;
    logic       drdy;
    logic       hreq;
    logic [8:0] fl;
  } stim_t;

  typedef struct packed {
    logic [11:0] o;
    logic        chk;
    logic [1:0]  st;
    logic [31:0] n;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_MEM_RDY = 1'b0;
  logic        D_MEM_RDY = 1'b0;
  logic        HALT_REQ = 1'b0;
  logic [8:0]  fl = '0;
  logic        isIF, isID, isEX, isMEM, isWB;
  logic        I_MEM_REQ, IR_WE, PC_WE, D_MEM_REQ;
  logic        D_MEM_WE, RF_WE_EN, ILLEGAL;
  logic        HALTED, MEM_ERR;
  logic [31:0] NUM_INST;

  multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(MT)) dut (
    .CLK(CLK), .RST(RST),
    .I_MEM_RDY(I_MEM_RDY), .D_MEM_RDY(D_MEM_RDY),
    .sigJAL(fl[0]), .sigJALR(fl[1]), .sigBRANCH(fl[2]),
    .sigLOAD(fl[3]), .sigSTORE(fl[4]), .sigOP(fl[5]),
    .sigOpIMM(fl[6]), .sigLUI(fl[7]), .sigAUIPC(fl[8]),
    .HALT_REQ(HALT_REQ),
    .isIF(isIF), .isID(isID), .isEX(isEX),
    .isMEM(isMEM), .isWB(isWB),
    .I_MEM_REQ(I_MEM_REQ), .IR_WE(IR_WE), .PC_WE(PC_WE),
    .D_MEM_REQ(D_MEM_REQ), .D_MEM_WE(D_MEM_WE),
    .RF_WE_EN(RF_WE_EN), .ILLEGAL(ILLEGAL),
    .HALTED(HALTED), .MEM_ERR(MEM_ERR),
    .NUM_INST(NUM_INST)
  );

  always #5 CLK = ~CLK;

  stim_t       sq[$];
  exp_t        eq[$];
  int          n_asrt = 0;
  int          n_fail = 0;
  logic [31:0] m_cnt = '0;
  logic        m_halt = 1'b0;
  logic        m_err = 1'b0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [8:0] r9();
    return 9'($urandom);
  endfunction

  task automatic push(input logic rst, input logic irdy,
                      input logic drdy, input logic hreq,
                      input logic [8:0] f, input logic [11:0] o);
    stim_t s;
    exp_t  e;
    s = '{rst: rst, irdy: irdy, drdy: drdy, hreq: hreq, fl: f};
    e.o   = o;
    e.chk = !rst;
    e.st  = {m_halt, m_err};
    e.n   = m_cnt;
    sq.push_back(s);
    eq.push_back(e);
    if (o[4]) m_cnt = m_cnt + 1;
    if (rst) begin
      m_cnt  = '0;
      m_halt = 1'b0;
      m_err  = 1'b0;
    end
  endtask

  task automatic do_reset();
    push(1'b1, rb(), rb(), rb(), r9(), 12'h000);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, rb(), rb(), rb(), r9(), 12'h000);
  endtask

  // fw/mw: not-ready cycles before the ready arrives
  task automatic instr(input int fw, input logic [8:0] f,
                       input logic hreq, input int mw);
    int  cls;
    logic st;
    for (int i = 0; ; i++) begin
      if (i == fw) begin
        push(1'b0, 1'b1, rb(), rb(), r9(), B_IF | B_IREQ | B_IRWE);
        break;
      end
      push(1'b0, 1'b0, rb(), rb(), r9(), B_IF | B_IREQ);
      if (i == MT - 1) begin
        m_halt = 1'b1;
        m_err  = 1'b1;
        return;
      end
    end
    cls = -1;
    for (int b = 8; b >= 0; b--)
      if (f[b]) cls = b;
    if (hreq) begin
      push(1'b0, rb(), rb(), 1'b1, f, B_ID);
      m_halt = 1'b1;
      return;
    end
    if (cls < 0) begin
      push(1'b0, rb(), rb(), 1'b0, f, B_ID | B_PC | B_ILL);
      return;
    end
    push(1'b0, rb(), rb(), 1'b0, f, B_ID);
    if (cls == 2) begin
      push(1'b0, rb(), rb(), rb(), r9(), B_EX | B_PC);
      return;
    end
    push(1'b0, rb(), rb(), rb(), r9(), B_EX);
    if (cls == 3 || cls == 4) begin
      st = (cls == 4);
      for (int i = 0; ; i++) begin
        if (i == mw) begin
          push(1'b0, rb(), 1'b1, rb(), r9(),
               B_MEM | B_DREQ | (st ? (B_DWE | B_PC) : 12'h000));
          break;
        end
        push(1'b0, rb(), 1'b0, rb(), r9(),
             B_MEM | B_DREQ | (st ? B_DWE : 12'h000));
        if (i == MT - 1) begin
          m_halt = 1'b1;
          m_err  = 1'b1;
          return;
        end
      end
      if (st) return;
    end
    push(1'b0, rb(), rb(), rb(), r9(), B_WB | B_RF | B_PC);
  endtask

  task automatic run();
    stim_t       s;
    exp_t        e;
    logic [11:0] o;
    while (sq.size() > 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      @(negedge CLK);
      RST       = s.rst;
      I_MEM_RDY = s.irdy;
      D_MEM_RDY = s.drdy;
      HALT_REQ  = s.hreq;
      fl        = s.fl;
      #1;
      o = {isIF, isID, isEX, isMEM, isWB, I_MEM_REQ, IR_WE,
           PC_WE, D_MEM_REQ, D_MEM_WE, RF_WE_EN, ILLEGAL};
      n_asrt++;
      if (o !== e.o) begin
        n_fail++;
        $display("FAIL strobes t=%0t got=%h want=%h", $time, o, e.o);
      end
      if (e.chk) begin
        n_asrt++;
        if ({HALTED, MEM_ERR} !== e.st || NUM_INST !== e.n) begin
          n_fail++;
          $display("FAIL status t=%0t got=%b/%0d want=%b/%0d",
                   $time, {HALTED, MEM_ERR}, NUM_INST, e.st, e.n);
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string nm, input int got, input int want);
    n_asrt++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  int b0;
  int fw;
  int mw;
  int pick;
  logic [8:0] f;

  initial begin
    do_reset();
    b0 = sq.size();
    instr(0, F_OPIMM, 1'b0, 0);
    lit("lat_opimm", sq.size() - b0, 4);
    run();
    lit("num_opimm", int'(NUM_INST), 1);

    do_reset();
    b0 = sq.size();
    instr(0, F_LOAD, 1'b0, 3);
    lit("lat_load3", sq.size() - b0, 8);
    run();
    lit("num_load", int'(NUM_INST), 1);

    do_reset();
    b0 = sq.size();
    instr(0, F_STORE, 1'b0, 0);
    lit("lat_store", sq.size() - b0, 4);
    b0 = sq.size();
    instr(0, F_BRANCH, 1'b0, 0);
    lit("lat_branch", sq.size() - b0, 3);
    run();
    lit("num_st_br", int'(NUM_INST), 2);

    do_reset();
    b0 = sq.size();
    instr(0, 9'h000, 1'b0, 0);
    lit("lat_illegal", sq.size() - b0, 2);
    run();
    lit("num_illegal", int'(NUM_INST), 1);

    do_reset();
    instr(1, F_JAL, 1'b0, 0);
    instr(0, F_LOAD | F_STORE, 1'b0, 1);
    instr(0, F_OPIMM, 1'b1, 0);
    halt_cycles(20);
    run();
    lit("num_halt", int'(NUM_INST), 2);
    lit("halted", int'(HALTED), 1);
    do_reset();
    instr(0, F_OPIMM, 1'b0, 0);
    run();

    do_reset();
    b0 = sq.size();
    instr(MT, F_OPIMM, 1'b0, 0);
    lit("lat_timeout", sq.size() - b0, MT);
    halt_cycles(3);
    run();
    lit("mem_err_to", int'(MEM_ERR), 1);

    do_reset();
    instr(MT - 1, F_OPIMM, 1'b0, 0);
    run();
    lit("mem_err_edge", int'(MEM_ERR), 0);

    do_reset();
    instr(0, F_LOAD, 1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      void'(sq.pop_back());
      void'(eq.pop_back());
    end
    do_reset();
    instr(0, F_STORE, 1'b0, MT);
    halt_cycles(2);
    do_reset();
    instr(0, F_OPIMM, 1'b0, 0);
    run();

    for (int k = 0; k < 250; k++) begin
      if (m_halt) begin
        halt_cycles($urandom_range(1, 4));
        do_reset();
      end else begin
        pick = $urandom_range(0, 19);
        fw = (pick == 0) ? MT : (pick == 1) ? MT - 1
           : $urandom_range(0, 3);
        pick = $urandom_range(0, 19);
        mw = (pick == 0) ? MT : (pick == 1) ? MT - 1
           : $urandom_range(0, 3);
        pick = $urandom_range(0, 9);
        if (pick == 0)     f = '0;
        else if (pick < 5) f = 9'(1 << $urandom_range(0, 8));
        else               f = r9();
        instr(fw, f, ($urandom_range(0, 29) == 0), mw);
      end
    end
    run();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
